// File: rtl/reg16_pkg.sv
// Shared types and helpers for the 16-bit register serial read-out path.
// Optional parity bit is enabled in reg16_shift_out by `define REG16_SHIFT_OUT_PARITY_EN.
package reg16_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIV   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A counter needs at least one bit even when it only ever holds 0.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg16_shift_out_bit_timer.sv
// Per-bit cycle counter: counts 0..DIV-1 and reports the last cycle of the
// current bit plus first/last decodes of the count the next cycle will hold.
module bit_timer
    import reg16_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic last,
    output logic first_next,
    output logic last_next
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    assign last       = (cnt_r == CNT_MAX);
    assign first_next = (cnt_s == CNT_ZERO);
    assign last_next  = (cnt_s == CNT_MAX);

    // Next count: wrap at the end of a bit, hold at zero while restarting.
    always_comb begin
        cnt_s = cnt_r;
        if (restart || last) begin
            cnt_s = CNT_ZERO;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: rtl/reg16_shift_out.sv
// Parallel-to-serial read-out of a register word, MSB first, DIV clocks per bit.
// `define REG16_SHIFT_OUT_PARITY_EN appends an even-parity bit to each frame.
module reg16_shift_out
    import reg16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int BW = clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [BW-1:0]    bit_r;
    logic [BW-1:0]    bit_s;
`ifdef REG16_SHIFT_OUT_PARITY_EN
    logic             par_r;
    logic             par_s;
`endif

    logic sdata_r;
    logic sframe_r;
    logic bit_strobe_r;
    logic busy_r;
    logic done_r;

    logic accept_s;
    logic restart_s;
    logic last_s;
    logic first_next_s;
    logic last_next_s;
    logic frame_s;
    logic sdata_s;

    assign in_ready   = (state_r == IDLE) && !reset;
    assign accept_s   = in_valid && in_ready;
    assign restart_s  = (state_r == IDLE);

    assign sdata      = sdata_r;
    assign sframe     = sframe_r;
    assign bit_strobe = bit_strobe_r;
    assign busy       = busy_r;
    assign done       = done_r;

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart_s),
        .last       (last_s),
        .first_next (first_next_s),
        .last_next  (last_next_s)
    );

    // Frame sequencing; the parity accumulator folds in each bit as it leaves.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        bit_s   = bit_r;
`ifdef REG16_SHIFT_OUT_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    shreg_s = in_data;
                    bit_s   = {BW{1'b0}};
`ifdef REG16_SHIFT_OUT_PARITY_EN
                    par_s   = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
`ifdef REG16_SHIFT_OUT_PARITY_EN
                    par_s   = par_r ^ shreg_r[WIDTH-1];
`endif
                    if (bit_r == LAST_BIT) begin
                        bit_s = {BW{1'b0}};
`ifdef REG16_SHIFT_OUT_PARITY_EN
                        state_s = PAR;
`else
                        state_s = GAP;
`endif
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
`ifdef REG16_SHIFT_OUT_PARITY_EN
            PAR: begin
                if (last_s) begin
                    state_s = GAP;
                end else begin
                    state_s = PAR;
                end
            end
`endif
            GAP: begin
                if (last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Serial line value for the cycle the next state covers.
    always_comb begin
        frame_s = (state_s == SHIFT) || (state_s == PAR);
        case (state_s)
            SHIFT:   sdata_s = shreg_s[WIDTH-1];
`ifdef REG16_SHIFT_OUT_PARITY_EN
            PAR:     sdata_s = par_s;
`endif
            default: sdata_s = 1'b0;
        endcase
    end

    // State, datapath and outputs all register from the next-state view.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            bit_r        <= {BW{1'b0}};
`ifdef REG16_SHIFT_OUT_PARITY_EN
            par_r        <= 1'b0;
`endif
            sdata_r      <= 1'b0;
            sframe_r     <= 1'b0;
            bit_strobe_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            bit_r        <= bit_s;
`ifdef REG16_SHIFT_OUT_PARITY_EN
            par_r        <= par_s;
`endif
            sdata_r      <= sdata_s;
            sframe_r     <= frame_s;
            bit_strobe_r <= frame_s && first_next_s;
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_s == GAP) && last_next_s;
        end
    end

endmodule

// File: tb/tb_reg16_shift_out.sv
// Scoreboard bench for reg16_shift_out (WIDTH=16, DIV=4), with or without
// REG16_SHIFT_OUT_PARITY_EN.
module tb_reg16_shift_out;

    localparam int W = 16;
    localparam int D = 4;
`ifdef REG16_SHIFT_OUT_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif
    localparam int FRAME = (FB + 1) * D;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         sdata;
    logic         sframe;
    logic         bit_strobe;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           acc_cyc[$];
    int           acc_cnt = 0;
    bit           act = 1'b0;
    bit           prev_rst = 1'b0;
    int           a_cyc = 0;
    logic [W-1:0] rx = '0;

    reg16_shift_out #(
        .WIDTH (W),
        .DIV   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sdata      (sdata),
        .sframe     (sframe),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // Reference model of the serial frame, evaluated mid-cycle.
    always @(negedge clk) begin
        int   k;
        int   b;
        bit   was_idle;
        logic [5:0] e;
        k = 0;
        b = 0;
        e = 6'd0;
        was_idle = !act;
        if (reset) begin
            check("rst_ready", 32'(in_ready), 32'd0);
            if (prev_rst) check("rst_outs", 32'({busy, sframe, bit_strobe, done, sdata}), 32'd0);
            act = 1'b0;
            exp_q.delete();
        end else begin
            if (act) begin
                k = cyc - a_cyc;
                e[4] = 1'b1;
                if (k <= FB * D) begin
                    b    = (k - 1) / D;
                    e[3] = 1'b1;
                    e[2] = ((k - 1) % D) == 0;
                    e[0] = (b < W) ? exp_q[0][W-1-b] : ^exp_q[0];
                    if (e[2] && b < W) rx = {rx[W-2:0], sdata};
                end else begin
                    e[1] = (k == FRAME);
                end
            end else begin
                e[5] = 1'b1;
            end
            check("outs{rdy,busy,frm,stb,done,sd}",
                  32'({in_ready, busy, sframe, bit_strobe, done, sdata}), 32'(e));
            if (act && k == FRAME) begin
                check("word", 32'(rx), 32'(exp_q.pop_front()));
                act = 1'b0;
            end
            if (was_idle && in_valid) begin
                exp_q.push_back(in_data);
                acc_cyc.push_back(cyc);
                acc_cnt++;
                a_cyc = cyc;
                act   = 1'b1;
                rx    = '0;
            end
        end
        prev_rst = reset;
    end

    task automatic send(input logic [W-1:0] w, input bit keep_valid);
        int n0;
        int t;
        n0 = acc_cnt;
        t  = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (acc_cnt == n0 && t < 4 * FRAME);
        if (acc_cnt == n0) check("accept_timeout", 32'(acc_cnt - n0), 32'd1);
        if (!keep_valid) begin
            in_valid = 1'b0;
            in_data  = ~w;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (act && t < 4 * FRAME) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (act) check("idle_timeout", 32'(act), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int t;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single word, then in_data changed right after accept.
        send(16'hA5C3, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held high.
        send(16'hFFFF, 1'b1);
        send(16'h0000, 1'b0);
        n = acc_cyc.size();
        check("b2b_gap", 32'(acc_cyc[n-1] - acc_cyc[n-2]), 32'(FRAME + 1));
        wait_idle();

        // in_valid pulsed mid-frame must be ignored.
        send(16'h5A5A, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        in_data  = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = acc_cnt;
        wait_idle();
        check("ignored_count", 32'(acc_cnt), 32'(n));

        // Reset 30 cycles into a frame.
        send(16'hC3A5, 1'b0);
        n = acc_cyc[acc_cyc.size()-1];
        t = 0;
        while (cyc != n + 30 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("abort_reach", 32'(cyc - n), 32'd30);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_sframe", 32'(sframe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'h8001, 1'b0);
        wait_idle();

        // Parity patterns plus a few random words.
        send(16'h0001, 1'b0);
        wait_idle();
        send(16'h0003, 1'b0);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            send(W'($urandom), 1'b0);
            wait_idle();
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
